// File: rtl/and4_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// and4_sweep_ctrl
//
// Clocked exerciser for a four-input AND block (e=a&b, f=c&d, g=e&f).
// A start pulse walks vec through 0..15 in ascending order. Each vector is held
// for HOLD_CYCLES settle cycles. The block's e/f/g are then compared once
// against the ideal AND results. The sweep reports a saturating mismatch count,
// the most recent failing vector, and a pass flag.
//
// Parameters:
//   HOLD_CYCLES  settle cycles per vector before sampling (legal 1..255)
//   ERR_W        width of err_cnt; the count saturates at 2^ERR_W-1
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous, active-high reset
//   start     single-cycle sweep request, honoured only in IDLE
//   abort     cancels a running sweep; wins over start in IDLE
//   vec       stimulus to the AND block: vec[3]=a, vec[2]=b, vec[1]=c, vec[0]=d
//   e_in      AND block output e
//   f_in      AND block output f
//   g_in      AND block output g
//   busy      high while a sweep is running
//   done      one-cycle pulse when a sweep completes
//   pass      completed sweep had zero mismatches; held until the next start
//   err_cnt   mismatching vectors in the current/last sweep (saturating)
//   fail_vec  most recent mismatching vector
//
// Build option:
//   SWEEP_STOP_ON_ERR_EN  when defined, the first mismatching vector ends the
//                         sweep and vec stays frozen at that vector.
// -----------------------------------------------------------------------------
module and4_sweep_ctrl #(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [3:0]       vec,
  input  logic             e_in,
  input  logic             f_in,
  input  logic             g_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       fail_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // HOLD_CYCLES never exceeds 255, so an 8-bit counter always covers it.
  localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  state_t     state;
  logic [7:0] hold;

  logic             exp_e, exp_f, exp_g;
  logic             mismatch;
  logic             last_vec;
  logic             finish_sweep;
  logic [ERR_W-1:0] err_next;

  // Ideal AND results for the vector currently driven, and the per-vector
  // mismatch flag (one count per vector however many outputs disagree).
  always_comb begin
    exp_e    = vec[3] & vec[2];
    exp_f    = vec[1] & vec[0];
    exp_g    = &vec;
    mismatch = (e_in != exp_e) || (f_in != exp_f) || (g_in != exp_g);
    last_vec = (vec == 4'hF);
    err_next = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + ERR_W'(1);
`ifdef SWEEP_STOP_ON_ERR_EN
    finish_sweep = last_vec || mismatch;
`else
    finish_sweep = last_vec;
`endif
  end

  // NOTE: all state lives in this one clocked block and uses non-blocking
  // assignments, so every output is a flop and update order never matters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      vec      <= 4'h0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      fail_vec <= 4'h0;
      hold     <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (!abort && start) begin
            vec      <= 4'h0;
            err_cnt  <= '0;
            fail_vec <= 4'h0;
            pass     <= 1'b0;
            hold     <= 8'h00;
            busy     <= 1'b1;
            state    <= SETTLE;
          end
        end

        SETTLE: begin
          if (abort) begin
            busy  <= 1'b0;
            pass  <= 1'b0;
            state <= IDLE;
          end else if (hold == HOLD_LAST) begin
            state <= CHECK;
          end else begin
            hold <= hold + 8'd1;
          end
        end

        CHECK: begin
          // An abort landing on the check cycle discards that vector's result.
          if (abort) begin
            busy  <= 1'b0;
            pass  <= 1'b0;
            state <= IDLE;
          end else begin
            if (mismatch) begin
              err_cnt  <= err_next;
              fail_vec <= vec;
            end
            if (finish_sweep) begin
              // err_cnt still holds the pre-check value here, so the final
              // vector's own result is folded in explicitly.
              pass  <= (err_cnt == '0) && !mismatch;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              vec   <= vec + 4'd1;
              hold  <= 8'h00;
              state <= SETTLE;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
